// File: rtl/reg_readback.sv
// Register read-back queue: captures the indexed 8-bit register on an accepted read
// request and streams it out through a small FIFO. Optional parity: REG_READBACK_PARITY_EN.
module reg_readback #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREGS*8-1:0]       reg_bus,
  input  logic                     rd_req,
  input  logic [AW-1:0]            rd_addr,
  output logic                     rd_ready,
`ifdef REG_READBACK_PARITY_EN
  output logic [8:0]               out_data,
`else
  output logic [7:0]               out_data,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     addr_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
`ifdef REG_READBACK_PARITY_EN
  localparam int unsigned DW = 9;
`else
  localparam int unsigned DW = 8;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [LW-1:0] level_nxt;
  logic [DW-1:0] data_nxt;
  logic [DW-1:0] entry_c;
  logic [7:0]    sel_c;
  logic          addr_ok_c;
  logic          push, pop;

  // Register select; out-of-range indices read as zero
  always_comb begin
    sel_c     = '0;
    addr_ok_c = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rd_addr == AW'(i)) begin
        sel_c     = reg_bus[8*i +: 8];
        addr_ok_c = 1'b1;
      end
    end
`ifdef REG_READBACK_PARITY_EN
    entry_c = {^sel_c, sel_c};
`else
    entry_c = sel_c;
`endif
  end

  // Next-state: pointers, occupancy and the registered head value
  always_comb begin
    push      = rd_req && rd_ready;
    pop       = out_valid && out_ready;
    wptr_nxt  = push ? wptr + PW'(1) : wptr;
    rptr_nxt  = pop  ? rptr + PW'(1) : rptr;
    level_nxt = level + LW'(push) - LW'(pop);
    data_nxt  = out_data;
    // The pushed entry becomes the head when nothing older survives this edge
    if (push && (level == '0 || (pop && level == LW'(1)))) begin
      data_nxt = entry_c;
    end else if (pop && level > LW'(1)) begin
      data_nxt = mem[rptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      rd_ready  <= 1'b1;
      out_data  <= '0;
      addr_err  <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      rd_ready  <= (level_nxt != LW'(DEPTH));
      out_data  <= data_nxt;
      addr_err  <= addr_err | (push & ~addr_ok_c);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= entry_c;
  end

endmodule

// File: tb/tb_reg_readback.sv
// Self-checking bench for reg_readback: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_reg_readback;

  localparam int unsigned NREGS = 3;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef REG_READBACK_PARITY_EN
  localparam int unsigned DW = 9;
`else
  localparam int unsigned DW = 8;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREGS*8-1:0] reg_bus;
  logic [7:0]         regs [NREGS];
  logic               rd_req;
  logic [AW-1:0]      rd_addr;
  logic               rd_ready;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic [LW-1:0]      level;
  logic               addr_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_last;
  bit            m_err;
  bit            m_push, m_pop;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREGS; i++) reg_bus[8*i +: 8] = regs[i];
  end

  reg_readback #(.NREGS(NREGS), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .reg_bus(reg_bus), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .addr_err(addr_err)
  );

  function automatic logic [DW-1:0] enc(input logic [7:0] v);
`ifdef REG_READBACK_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of captured values
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_last = '0;
      m_err  = 1'b0;
    end else begin
      m_push = rd_req && (q.size() < DEPTH);
      m_pop  = out_ready && (q.size() > 0);
      if (m_pop) m_last = q.pop_front();
      if (m_push) begin
        if (int'(rd_addr) < NREGS) q.push_back(enc(regs[rd_addr]));
        else begin
          q.push_back('0);
          m_err = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("m_level", 32'(level), 32'(q.size()));
      check("m_valid", 32'(out_valid), 32'(q.size() != 0));
      check("m_ready", 32'(rd_ready), 32'(q.size() != DEPTH));
      check("m_data", 32'(out_data), 32'(q.size() != 0 ? q[0] : m_last));
      check("m_err", 32'(addr_err), 32'(m_err));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [7:0] exp_seq [5];

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; out_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    tick(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(1);
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ready", 32'(rd_ready), 1);
    check("rst_err", 32'(addr_err), 0);

    // Single read
    regs[2] = 8'hA5; out_ready = 1'b1; rd_req = 1'b1; rd_addr = 2'd2;
    tick(1);
    rd_req = 1'b0;
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 32'(enc(8'hA5)));
    tick(1);
    check("single_drain_valid", 32'(out_valid), 0);
    check("single_drain_level", 32'(level), 0);

    // Fill and backpressure
    out_ready = 1'b0;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33;
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i % 3);
      tick(1);
    end
    rd_addr = 2'd1;
    tick(2);
    check("full_level", 32'(level), 4);
    check("full_ready", 32'(rd_ready), 0);
    out_ready = 1'b1;
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    exp_seq[3] = 8'h11; exp_seq[4] = 8'h22;
    for (int k = 0; k < 5; k++) begin
      check("drain_data", 32'(out_data), 32'(enc(exp_seq[k])));
      tick(1);
      if (k == 1) rd_req = 1'b0;
    end
    check("drain_empty", 32'(out_valid), 0);

    // Simultaneous push/pop across pointer wrap
    out_ready = 1'b0; rd_addr = 2'd0; rd_req = 1'b1;
    for (int v = 0; v < 2; v++) begin
      regs[0] = 8'(v);
      tick(1);
    end
    out_ready = 1'b1;
    for (int v = 2; v < 10; v++) begin
      regs[0] = 8'(v);
      tick(1);
      check("pp_level", 32'(level), 2);
    end
    rd_req = 1'b0;
    tick(3);

    // Out-of-range read
    rd_req = 1'b1; rd_addr = 2'd3;
    tick(1);
    rd_req = 1'b0;
    check("oor_data", 32'(out_data), 0);
    check("oor_valid", 32'(out_valid), 1);
    check("oor_err", 32'(addr_err), 1);
    rd_req = 1'b1; rd_addr = 2'd1;
    tick(1);
    rd_req = 1'b0;
    tick(2);
    check("oor_err_sticky", 32'(addr_err), 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("oor_err_cleared", 32'(addr_err), 0);

    // Asynchronous reset mid-operation
    out_ready = 1'b0; rd_req = 1'b1; rd_addr = 2'd2;
    tick(3);
    rd_req = 1'b0;
    check("mid_level_pre", 32'(level), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_level", 32'(level), 0);
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(2);
    check("mid_after_valid", 32'(out_valid), 0);

`ifdef REG_READBACK_PARITY_EN
    regs[0] = 8'h07; rd_req = 1'b1; rd_addr = 2'd0; out_ready = 1'b0;
    tick(1);
    rd_req = 1'b0;
    check("parity_data", 32'(out_data), 32'h107);
    out_ready = 1'b1;
    tick(2);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rd_req    = ($urandom_range(0, 99) < 60);
      rd_addr   = AW'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 99) < 50);
      regs[$urandom_range(0, NREGS - 1)] = 8'($urandom);
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick(1);
    end
    rd_req = 1'b0; out_ready = 1'b1;
    tick(DEPTH + 2);
    check("final_empty", 32'(level), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_readback.md
Name: reg_readback

Overview:
Read-side counterpart to the 8-bit loadable registers. It takes read requests by register index, captures the selected register's current value, and queues it in a small FIFO. Queued values go out on a valid/ready stream toward the bus/output stage. It decouples CPU register storage from a slower consumer, such as a debug port or output device.

Parameters:
NREGS, 4, number of 8-bit registers presented on reg_bus (1..16)
AW, 2, width of rd_addr; must satisfy 2**AW >= NREGS
DEPTH, 4, FIFO entries (power of two, 2..16)

Ports:
clk  input  1  clock; all state updates on posedge clk
rst_n  input  1  asynchronous active-low reset
reg_bus  input  NREGS*8  flattened register contents; register i at bits [8*i+7:8*i]
rd_req  input  1  read request
rd_addr  input  AW  register index for rd_req
rd_ready  output  1  request accept; high when FIFO not full
out_data  output  8  data at FIFO head (parity in bit 8 when feature enabled, see below)
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data
level  output  $clog2(DEPTH)+1  current FIFO occupancy
addr_err  output  1  sticky flag: an accepted request used rd_addr >= NREGS

Behaviour:
- Reset (rst_n low, asynchronous) forces these values:
  - FIFO empty; level=0; out_valid=0; out_data=0; addr_err=0; rd_ready=1 (once rst_n is high).
  - Reset mid-operation discards all queued entries.
- Accept: rd_req && rd_ready at posedge clk.
  - Captures reg_bus[8*rd_addr +: 8] as sampled at that edge.
  - A register load on the same edge is not seen; the old value is captured.
- Out-of-range rd_addr (>= NREGS) on accept:
  - The entry is still pushed, with value 8'h00.
  - addr_err is set and stays 1 until reset.
- Latency: a request accepted at edge N into an empty FIFO gives out_valid=1 and out_data=value from edge N onward (visible the cycle after N). There is no combinational bypass.
- Pop: out_valid && out_ready at posedge. The head advances, and the next entry appears the following cycle.
- out_data holds stable while out_valid && !out_ready.
- When empty, out_data holds the last popped value (0 after reset); consumers must ignore it.
- rd_ready = (level != DEPTH), registered-state based. It does not depend on out_ready in the same cycle, so there is no push-through when full.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged, order preserved.
- When level=0, only a push can occur.
- rd_req while full (rd_ready=0): the request is ignored. The requester must hold it until accepted; dropped requests are not recorded.
- Read and write pointers are AW-independent with $clog2(DEPTH) bits. They wrap modulo DEPTH; level distinguishes full from empty.
- Strict FIFO ordering; no reordering or coalescing of duplicate addresses.

Optional Feature:
- Macro: REG_READBACK_PARITY_EN
- When defined:
  - out_data widens to 9 bits, with out_data[8] = even parity (XOR) of bits [7:0], computed at capture and stored with the entry.
  - FIFO storage is 9 bits wide.
  - An out-of-range read stores 9'h000.
- When undefined: out_data is 8 bits, with no parity storage or logic.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then high → level=0, out_valid=0, out_data=0, rd_ready=1, addr_err=0.
- Single read: reg_bus register 2 = 8'hA5; pulse rd_req with rd_addr=2 for one cycle, out_ready=1 → next cycle out_valid=1, out_data=8'hA5; following cycle out_valid=0, level=0.
- Fill and backpressure:
  - Stimulus: out_ready=0; registers 0..3 = 8'h11,8'h22,8'h33,8'h44; read 0,1,2,3, then hold rd_req with rd_addr=0.
  - Response: level=4 and rd_ready=0; 5th request not accepted.
  - Then out_ready=1: pops 8'h11,8'h22,8'h33,8'h44 in order, then 8'h11 once the held request is accepted.
- Simultaneous push/pop: level=2, rd_req=1 and out_ready=1 in the same cycle → level stays 2; data order intact across pointer wrap (run 10 continuous transfers, values 0..9 out in order).
- Out-of-range (NREGS=3, AW=2): read rd_addr=3 → entry 8'h00 delivered, addr_err=1; a later valid read leaves addr_err=1 until rst_n pulse clears it.
- Reset mid-operation: level=3, assert rst_n low asynchronously between edges → out_valid and level drop to 0 immediately; no old data after release. With REG_READBACK_PARITY_EN, read 8'h07 → out_data=9'h107.
